// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared definitions for the stopwatch controller:
//   - FSM state encoding (IDLE, RUN, LAP, PAUSE)
//   - counter field widths matching the display ports
//   - default terminal counts (59:59.999 full scale)
//   - is_counting(): true in the states where millisecond ticks advance time
// Optional build macro used by the importing files: STOPWATCH_OVF_STOP_EN
// -----------------------------------------------------------------------------
package stopwatch_pkg;

    localparam int MS_W  = 10;
    localparam int SEC_W = 6;
    localparam int MIN_W = 6;

    localparam logic [MS_W-1:0]  MS_MAX_DEF  = 10'd999;
    localparam logic [SEC_W-1:0] SEC_MAX_DEF = 6'd59;
    localparam logic [MIN_W-1:0] MIN_MAX_DEF = 6'd59;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        LAP   = 2'd2,
        PAUSE = 2'd3
    } sw_state_e;

    // Live time advances in RUN and in LAP (the lap freeze only affects display).
    function automatic logic is_counting(input sw_state_e st);
        return (st == RUN) || (st == LAP);
    endfunction

endpackage

// File: rtl/sw_time_cnt.sv
// -----------------------------------------------------------------------------
// sw_time_cnt
// Cascaded minutes:seconds.milliseconds counter.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   inc          in   advance by one millisecond this cycle
//   clr          in   synchronous clear of all three fields
//   hold_at_max  in   when 1, a full-scale increment holds instead of wrapping
//   ms_cnt       out  milliseconds field (registered)
//   sec_cnt      out  seconds field (registered)
//   min_cnt      out  minutes field (registered)
//   full         out  combinational carry: inc while at MIN_MAX:SEC_MAX.MS_MAX
// Used with the build macro STOPWATCH_OVF_STOP_EN via hold_at_max in the top.
// -----------------------------------------------------------------------------
module sw_time_cnt
    import stopwatch_pkg::*;
#(
    parameter logic [MS_W-1:0]  MS_MAX  = MS_MAX_DEF,
    parameter logic [SEC_W-1:0] SEC_MAX = SEC_MAX_DEF,
    parameter logic [MIN_W-1:0] MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             hold_at_max,
    output logic [MS_W-1:0]  ms_cnt,
    output logic [SEC_W-1:0] sec_cnt,
    output logic [MIN_W-1:0] min_cnt,
    output logic             full
);

    logic [MS_W-1:0]  ms_r,  ms_nxt_s;
    logic [SEC_W-1:0] sec_r, sec_nxt_s;
    logic [MIN_W-1:0] min_r, min_nxt_s;
    logic             ms_top_s;
    logic             sec_top_s;
    logic             min_top_s;
    logic             full_s;

    // Terminal-count detection for each field.
    always_comb begin
        ms_top_s  = (ms_r  == MS_MAX);
        sec_top_s = (sec_r == SEC_MAX);
        min_top_s = (min_r == MIN_MAX);
        full_s    = inc && ms_top_s && sec_top_s && min_top_s;
    end

    // Next value of the cascade: ms carries into sec, sec carries into min.
    always_comb begin
        ms_nxt_s  = ms_r;
        sec_nxt_s = sec_r;
        min_nxt_s = min_r;
        if (clr) begin
            ms_nxt_s  = MS_W'(0);
            sec_nxt_s = SEC_W'(0);
            min_nxt_s = MIN_W'(0);
        end else if (inc) begin
            if (full_s && hold_at_max) begin
                // Saturate at full scale.
                ms_nxt_s  = ms_r;
                sec_nxt_s = sec_r;
                min_nxt_s = min_r;
            end else if (ms_top_s) begin
                ms_nxt_s = MS_W'(0);
                if (sec_top_s) begin
                    sec_nxt_s = SEC_W'(0);
                    if (min_top_s) begin
                        min_nxt_s = MIN_W'(0);
                    end else begin
                        min_nxt_s = min_r + MIN_W'(1);
                    end
                end else begin
                    sec_nxt_s = sec_r + SEC_W'(1);
                end
            end else begin
                ms_nxt_s = ms_r + MS_W'(1);
            end
        end else begin
            ms_nxt_s  = ms_r;
            sec_nxt_s = sec_r;
            min_nxt_s = min_r;
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ms_r  <= MS_W'(0);
            sec_r <= SEC_W'(0);
            min_r <= MIN_W'(0);
        end else begin
            ms_r  <= ms_nxt_s;
            sec_r <= sec_nxt_s;
            min_r <= min_nxt_s;
        end
    end

    assign ms_cnt  = ms_r;
    assign sec_cnt = sec_r;
    assign min_cnt = min_r;
    assign full    = full_s;

endmodule

// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Stopwatch controller: decodes start/stop, lap and clear pulses into an
// IDLE/RUN/LAP/PAUSE FSM, accumulates elapsed time from 1 ms ticks, keeps a
// lap snapshot, and presents live or lap-frozen time to the display.
// Ports:
//   clk            in   system clock (shared with the tick generator)
//   rst            in   synchronous active-high reset
//   ms             in   1 ms tick pulse
//   cmd_startstop  in   toggle run/pause
//   cmd_lap        in   freeze / release the display
//   cmd_clear      in   zero time while paused
//   tick_clr       out  restart strobe to the tick generator (combinational)
//   running        out  state is RUN or LAP
//   lap_active     out  state is LAP
//   ovf            out  sticky full-scale flag
//   disp_min/sec/ms out displayed time
// Build macro: STOPWATCH_OVF_STOP_EN -- when defined, full scale saturates
// the counters, forces PAUSE, and blocks resume until cmd_clear.
// -----------------------------------------------------------------------------
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter logic [MS_W-1:0]  MS_MAX  = MS_MAX_DEF,
    parameter logic [SEC_W-1:0] SEC_MAX = SEC_MAX_DEF,
    parameter logic [MIN_W-1:0] MIN_MAX = MIN_MAX_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ms,
    input  logic             cmd_startstop,
    input  logic             cmd_lap,
    input  logic             cmd_clear,
    output logic             tick_clr,
    output logic             running,
    output logic             lap_active,
    output logic             ovf,
    output logic [MIN_W-1:0] disp_min,
    output logic [SEC_W-1:0] disp_sec,
    output logic [MS_W-1:0]  disp_ms
);

    sw_state_e        state_r, state_nxt_s;
    logic             tick_clr_s;
    logic             lap_cap_s;
    logic             cnt_clr_s;
    logic             inc_s;
    logic             full_s;
    logic             hold_s;
    logic             force_pause_s;
    logic             stop_lock_s;
    logic             ovf_r;

    logic [MS_W-1:0]  live_ms_s;
    logic [SEC_W-1:0] live_sec_s;
    logic [MIN_W-1:0] live_min_s;
    logic [MS_W-1:0]  lap_ms_r;
    logic [SEC_W-1:0] lap_sec_r;
    logic [MIN_W-1:0] lap_min_r;

`ifdef STOPWATCH_OVF_STOP_EN
    // Saturate at full scale, drop into PAUSE, and refuse to resume until cleared.
    assign hold_s        = 1'b1;
    assign force_pause_s = full_s;
    assign stop_lock_s   = ovf_r;
`else
    // Wrap to zero at full scale and keep counting.
    assign hold_s        = 1'b0;
    assign force_pause_s = 1'b0;
    assign stop_lock_s   = 1'b0;
`endif

    // Ticks are gated by the current (pre-edge) state, so a tick alongside the
    // pausing command is counted and one alongside a resume is not.
    assign inc_s = ms && is_counting(state_r);

    sw_time_cnt #(
        .MS_MAX  (MS_MAX),
        .SEC_MAX (SEC_MAX),
        .MIN_MAX (MIN_MAX)
    ) u_time_cnt (
        .clk         (clk),
        .rst         (rst),
        .inc         (inc_s),
        .clr         (cnt_clr_s),
        .hold_at_max (hold_s),
        .ms_cnt      (live_ms_s),
        .sec_cnt     (live_sec_s),
        .min_cnt     (live_min_s),
        .full        (full_s)
    );

    // Command decode: clear > startstop > lap; illegal commands fall through.
    always_comb begin
        state_nxt_s = state_r;
        tick_clr_s  = 1'b0;
        lap_cap_s   = 1'b0;
        cnt_clr_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (cmd_startstop) begin
                    state_nxt_s = RUN;
                    tick_clr_s  = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                if (force_pause_s) begin
                    state_nxt_s = PAUSE;
                end else if (cmd_startstop) begin
                    state_nxt_s = PAUSE;
                end else if (cmd_lap) begin
                    state_nxt_s = LAP;
                    lap_cap_s   = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            LAP: begin
                if (force_pause_s) begin
                    state_nxt_s = PAUSE;
                end else if (cmd_startstop) begin
                    state_nxt_s = PAUSE;
                end else if (cmd_lap) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = LAP;
                end
            end
            PAUSE: begin
                if (cmd_clear) begin
                    state_nxt_s = IDLE;
                    cnt_clr_s   = 1'b1;
                end else if (cmd_startstop && !stop_lock_s) begin
                    // Resume keeps the sub-ms phase: no tick generator restart.
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = PAUSE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Lap snapshot: takes the live value as it stood before this edge's tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            lap_ms_r  <= MS_W'(0);
            lap_sec_r <= SEC_W'(0);
            lap_min_r <= MIN_W'(0);
        end else if (cnt_clr_s) begin
            lap_ms_r  <= MS_W'(0);
            lap_sec_r <= SEC_W'(0);
            lap_min_r <= MIN_W'(0);
        end else if (lap_cap_s) begin
            lap_ms_r  <= live_ms_s;
            lap_sec_r <= live_sec_s;
            lap_min_r <= live_min_s;
        end else begin
            lap_ms_r  <= lap_ms_r;
            lap_sec_r <= lap_sec_r;
            lap_min_r <= lap_min_r;
        end
    end

    // Sticky full-scale flag, released only by a clear from PAUSE.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (cnt_clr_s) begin
            ovf_r <= 1'b0;
        end else if (full_s) begin
            ovf_r <= 1'b1;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Display source: the lap snapshot while frozen, live time otherwise.
    always_comb begin
        disp_min = live_min_s;
        disp_sec = live_sec_s;
        disp_ms  = live_ms_s;
        if (state_r == LAP) begin
            disp_min = lap_min_r;
            disp_sec = lap_sec_r;
            disp_ms  = lap_ms_r;
        end else begin
            disp_min = live_min_s;
            disp_sec = live_sec_s;
            disp_ms  = live_ms_s;
        end
    end

    assign tick_clr   = tick_clr_s;
    assign running    = is_counting(state_r);
    assign lap_active = (state_r == LAP);
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Directed bench for stopwatch_ctrl. dut_a uses the default 59:59.999 scale
// and is driven from a vector table; dut_b uses a reduced 2:05.009 scale so
// the full-scale corner is reachable in a few hundred ticks.
// Honours STOPWATCH_OVF_STOP_EN for the full-scale expectations.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       a_ms, a_ss, a_lp, a_cl;
    logic       a_tick, a_run, a_lapa, a_ovf;
    logic [5:0] a_min, a_sec;
    logic [9:0] a_msd;
    logic       b_ms, b_ss, b_lp, b_cl;
    logic       b_tick, b_run, b_lapa, b_ovf;
    logic [5:0] b_min, b_sec;
    logic [9:0] b_msd;

    int n_cmp     = 0;
    int n_bad     = 0;
    int tick_seen = 0;

    stopwatch_ctrl dut_a (
        .clk(clk), .rst(rst), .ms(a_ms),
        .cmd_startstop(a_ss), .cmd_lap(a_lp), .cmd_clear(a_cl),
        .tick_clr(a_tick), .running(a_run), .lap_active(a_lapa), .ovf(a_ovf),
        .disp_min(a_min), .disp_sec(a_sec), .disp_ms(a_msd)
    );

    stopwatch_ctrl #(.MS_MAX(10'd9), .SEC_MAX(6'd5), .MIN_MAX(6'd2)) dut_b (
        .clk(clk), .rst(rst), .ms(b_ms),
        .cmd_startstop(b_ss), .cmd_lap(b_lp), .cmd_clear(b_cl),
        .tick_clr(b_tick), .running(b_run), .lap_active(b_lapa), .ovf(b_ovf),
        .disp_min(b_min), .disp_sec(b_sec), .disp_ms(b_msd)
    );

    // Count restart strobes from dut_a, sampled mid-cycle once inputs settle.
    always @(negedge clk) begin
        #2;
        if (a_tick === 1'b1) tick_seen++;
    end

    typedef struct {
        logic ss, lp, cl, ms;
        int   n;
        logic e_tick, e_run, e_lap, e_ovf;
        int   e_min, e_sec, e_ms;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ss, input logic lp, input logic cl,
                                input logic m, input int n, input logic et,
                                input logic er, input logic el, input logic eo,
                                input int mi, input int se, input int ml);
        vec_t v;
        v.ss = ss; v.lp = lp; v.cl = cl; v.ms = m; v.n = n;
        v.e_tick = et; v.e_run = er; v.e_lap = el; v.e_ovf = eo;
        v.e_min = mi; v.e_sec = se; v.e_ms = ml;
        return v;
    endfunction

    task automatic check_out(input string nm, input logic r, input logic l,
                             input logic o, input logic [5:0] mi,
                             input logic [5:0] se, input logic [9:0] md,
                             input logic er, input logic el, input logic eo,
                             input int emi, input int ese, input int ems);
        n_cmp++;
        if ({r, l, o, mi, se, md} !== {er, el, eo, 6'(emi), 6'(ese), 10'(ems)}) begin
            n_bad++;
            $display("FAIL %s: got run=%0b lap=%0b ovf=%0b %0d:%0d.%0d, need run=%0b lap=%0b ovf=%0b %0d:%0d.%0d",
                     nm, r, l, o, mi, se, md, er, el, eo, emi, ese, ems);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, need %0d", nm, act, exp);
        end
    endtask

    task automatic step_a(input logic ss, input logic lp, input logic cl,
                          input logic m, input int n, input logic e_tick,
                          input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            a_ss = ss; a_lp = lp; a_cl = cl; a_ms = m;
            #1;
            if (k == 0) check_int({nm, " tick_clr"}, int'(a_tick), int'(e_tick));
            @(posedge clk);
            #1;
            a_ss = 1'b0; a_lp = 1'b0; a_cl = 1'b0; a_ms = 1'b0;
        end
    endtask

    task automatic step_b(input logic ss, input logic cl, input logic m,
                          input int n, input logic e_tick, input string nm);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            b_ss = ss; b_cl = cl; b_ms = m;
            #1;
            if (k == 0) check_int({nm, " tick_clr"}, int'(b_tick), int'(e_tick));
            @(posedge clk);
            #1;
            b_ss = 1'b0; b_cl = 1'b0; b_ms = 1'b0;
        end
    endtask

    // Run-away guard.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //              ss lp cl ms  n    tk run lap ovf min sec ms
        tbl.push_back(mk(0, 0, 0, 1, 5,    0, 0, 0, 0, 0, 0, 0));    // ticks in IDLE
        tbl.push_back(mk(0, 1, 1, 0, 1,    0, 0, 0, 0, 0, 0, 0));    // lap/clear in IDLE
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 0, 0, 0, 0, 0));    // start
        tbl.push_back(mk(0, 0, 0, 1, 1500, 0, 1, 0, 0, 0, 1, 500));
        tbl.push_back(mk(1, 0, 0, 0, 1,    0, 0, 0, 0, 0, 1, 500));  // pause
        tbl.push_back(mk(0, 0, 1, 0, 1,    0, 0, 0, 0, 0, 0, 0));    // clear
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 250,  0, 1, 0, 0, 0, 0, 250));
        tbl.push_back(mk(1, 0, 0, 0, 1,    0, 0, 0, 0, 0, 0, 250));  // pause
        tbl.push_back(mk(0, 0, 0, 1, 100,  0, 0, 0, 0, 0, 0, 250));  // ticks in PAUSE
        tbl.push_back(mk(1, 0, 0, 1, 1,    0, 1, 0, 0, 0, 0, 250));  // resume + tick
        tbl.push_back(mk(0, 0, 0, 1, 10,   0, 1, 0, 0, 0, 0, 260));
        tbl.push_back(mk(0, 0, 0, 1, 1740, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1,    0, 1, 1, 0, 0, 2, 0));    // lap
        tbl.push_back(mk(0, 0, 0, 1, 500,  0, 1, 1, 0, 0, 2, 0));    // frozen
        tbl.push_back(mk(0, 1, 0, 0, 1,    0, 1, 0, 0, 0, 2, 500));  // release
        tbl.push_back(mk(0, 1, 0, 1, 1,    0, 1, 1, 0, 0, 2, 500));  // lap + tick
        tbl.push_back(mk(0, 0, 1, 1, 1,    0, 1, 1, 0, 0, 2, 500));  // clear in LAP
        tbl.push_back(mk(1, 1, 0, 0, 1,    0, 0, 0, 0, 0, 2, 502));  // LAP -> PAUSE
        tbl.push_back(mk(1, 0, 1, 0, 1,    0, 0, 0, 0, 0, 0, 0));    // clear wins
        tbl.push_back(mk(1, 0, 0, 0, 1,    1, 1, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3,    0, 1, 0, 0, 0, 0, 3));
        tbl.push_back(mk(1, 0, 0, 1, 1,    0, 0, 0, 0, 0, 0, 4));    // pause + tick
        tbl.push_back(mk(1, 1, 0, 0, 1,    0, 1, 0, 0, 0, 0, 4));    // resume
        tbl.push_back(mk(1, 1, 0, 0, 1,    0, 0, 0, 0, 0, 0, 4));    // pause beats lap
        tbl.push_back(mk(1, 0, 0, 0, 1,    0, 1, 0, 0, 0, 0, 4));
        tbl.push_back(mk(0, 0, 0, 1, 5119, 0, 1, 0, 0, 0, 5, 123));
        tbl.push_back(mk(0, 1, 0, 0, 1,    0, 1, 1, 0, 0, 5, 123));  // lap at 0:05.123

        rst = 1'b1;
        a_ss = 1'b0; a_lp = 1'b0; a_cl = 1'b0; a_ms = 1'b1;
        b_ss = 1'b0; b_lp = 1'b0; b_cl = 1'b0; b_ms = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; a_ms = 1'b0; b_ms = 1'b0;
        check_out("reset_a", a_run, a_lapa, a_ovf, a_min, a_sec, a_msd, 0, 0, 0, 0, 0, 0);
        check_out("reset_b", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 0, 0, 0, 0, 0, 0);
        check_int("reset tick_clr", int'(a_tick), 0);

        for (int i = 0; i < tbl.size(); i++) begin
            step_a(tbl[i].ss, tbl[i].lp, tbl[i].cl, tbl[i].ms, tbl[i].n,
                   tbl[i].e_tick, $sformatf("vec%0d", i));
            check_out($sformatf("vec%0d", i), a_run, a_lapa, a_ovf, a_min, a_sec, a_msd,
                      tbl[i].e_run, tbl[i].e_lap, tbl[i].e_ovf,
                      tbl[i].e_min, tbl[i].e_sec, tbl[i].e_ms);
        end
        check_int("tick_clr count after table", tick_seen, 3);

        // Reset during LAP, with commands and a tick in the same cycle.
        @(negedge clk);
        rst = 1'b1; a_ss = 1'b1; a_lp = 1'b1; a_ms = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; a_ss = 1'b0; a_lp = 1'b0; a_ms = 1'b0;
        check_out("mid_reset", a_run, a_lapa, a_ovf, a_min, a_sec, a_msd, 0, 0, 0, 0, 0, 0);
        step_a(0, 0, 0, 1, 3, 0, "post_reset_ticks");
        check_out("post_reset_idle", a_run, a_lapa, a_ovf, a_min, a_sec, a_msd, 0, 0, 0, 0, 0, 0);
        step_a(1, 0, 0, 0, 1, 1, "post_reset_start");
        check_out("post_reset_run", a_run, a_lapa, a_ovf, a_min, a_sec, a_msd, 1, 0, 0, 0, 0, 0);
        check_int("tick_clr count final", tick_seen, 4);

        // Reduced-scale instance: carries and the full-scale corner.
        step_b(1, 0, 0, 1, 1, "b_start");
        step_b(0, 0, 1, 10, 0, "b_10");
        check_out("b_sec_carry", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 0, 0, 1, 0);
        step_b(0, 0, 1, 50, 0, "b_60");
        check_out("b_min_carry", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 0, 1, 0, 0);
        step_b(0, 0, 1, 118, 0, "b_178");
        check_out("b_preload", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 0, 2, 5, 8);
        step_b(0, 0, 1, 1, 0, "b_179");
        check_out("b_at_max", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 0, 2, 5, 9);
        step_b(0, 0, 1, 1, 0, "b_180");
`ifdef STOPWATCH_OVF_STOP_EN
        check_out("b_full_hold", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 0, 0, 1, 2, 5, 9);
        step_b(1, 0, 0, 1, 0, "b_resume_blocked");
        check_out("b_still_paused", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 0, 0, 1, 2, 5, 9);
`else
        check_out("b_full_wrap", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 1, 0, 0, 0);
        step_b(0, 0, 1, 1, 0, "b_after_wrap");
        check_out("b_ovf_sticky", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 1, 0, 0, 1);
        step_b(1, 0, 0, 1, 0, "b_pause");
        check_out("b_paused", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 0, 0, 1, 0, 0, 1);
`endif
        step_b(0, 1, 0, 1, 0, "b_clear");
        check_out("b_cleared", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 0, 0, 0, 0, 0, 0);
        step_b(1, 0, 0, 1, 1, "b_restart");
        check_out("b_restarted", b_run, b_lapa, b_ovf, b_min, b_sec, b_msd, 1, 0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
